commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
Synthesizable trace monitor that sits beside the single-cycle/pipelined CPU core and records architectural register commits (PC, destination register, write data) into an on-chip circular buffer. It replaces free-running textual register dumps with a bounded, triggerable capture and a cycle budget. Captured entries drain through a valid/ready readout port to a host or debug UART.

Parameters:
DATA_W, 32, width of committed register data
PC_W, 32, width of PC and trigger compare
DEPTH, 16, trace entries (power of two, >=2)
CYC_W, 16, cycle counter width
MAX_CYCLES, 30, cycle budget; halt asserts when cycle_count reaches it (0 = no limit)
FILTER_ZERO, 1, 1 = drop commits to register 0

Ports:
SwitchClk_10  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
arm  in  1  single-cycle pulse: start/restart capture session
trig_mode  in  1  0 = capture immediately on arm; 1 = wait for PC match
trig_pc  in  PC_W  trigger PC
commit_valid  in  1  core retires an instruction with register write this cycle
commit_pc  in  PC_W  PC of retiring instruction
commit_rd  in  5  destination register index
commit_data  in  DATA_W  value written
rd_valid  out  1  head entry available
rd_ready  in  1  consumer accepts head entry
rd_pc  out  PC_W  head entry PC
rd_reg  out  5  head entry register index
rd_data  out  DATA_W  head entry data
count  out  log2(DEPTH)+1  entries held
state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
cycle_count  out  CYC_W  cycles since arm (or since reset)
halt  out  1  sticky: cycle budget exhausted
overflow  out  1  sticky: at least one commit dropped while full

Behaviour:
- Reset (reset=0, async): state=IDLE, all pointers/count=0, cycle_count=0, halt=0, overflow=0, rd_valid=0, rd_* =0.
- cycle_count: +1 every rising edge while state!=IDLE and halt=0; saturates at all-ones; cleared to 0 on arm.
- halt: set on the edge where cycle_count becomes MAX_CYCLES (MAX_CYCLES!=0); sticky until arm or reset; forces state->DONE same edge.
- FSM: IDLE --arm--> ARMED (trig_mode=1) or CAPTURE (trig_mode=0). ARMED --commit_valid & commit_pc==trig_pc--> CAPTURE; the matching commit is itself recorded. CAPTURE --halt--> DONE. Any state --arm--> ARMED/CAPTURE with buffer flushed, overflow/halt cleared. DONE holds until arm.
- Push: in CAPTURE (or triggering commit) when commit_valid=1 and not (FILTER_ZERO & commit_rd==0). Entry visible at rd_* one cycle after push (registered, first-word-fall-through).
- Pop: rd_valid & rd_ready on edge; next entry presented following cycle; rd_valid = (count!=0).
- Full (count==DEPTH) and push without pop: entry dropped, overflow=1, oldest data kept. Full with simultaneous pop: push accepted, count unchanged.
- Empty with simultaneous push and rd_ready: no pop; entry appears next cycle.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH.
- Readout continues in DONE and IDLE; arm flushes unread entries.
- Reset mid-capture: immediate return to reset values; no partial entries.

Optional Feature:
TRACE_TIMESTAMP_EN: when defined, each entry also stores cycle_count at push and adds output port rd_time (CYC_W) valid with rd_valid; reset value 0. When undefined, port and storage are absent; all other behaviour identical.

Test Plan:
- Reset low mid-run with count=5 -> next cycle count=0, state=0, rd_valid=0, halt=0, overflow=0.
- arm with trig_mode=0, commits rd=8 data 0x00000005, rd=9 data 0x0000000A at PCs 0x00003000/0x00003004 -> rd_valid; pops return exactly those entries in order, then rd_valid=0.
- trig_mode=1, trig_pc=0x0000300C; commits at 0x3000,0x3004,0x3008,0x300C,0x3010 -> state ARMED until 0x300C; only 0x300C and 0x3010 recorded (count=2).
- DEPTH=16, 18 valid commits with rd_ready=0 -> count=16, overflow=1, first popped PC is first commit; then push+pop simultaneous while full -> count stays 16.
- MAX_CYCLES=30, continuous commits -> halt=1 and state=DONE on 30th edge after arm, no further pushes; commit_rd=0 commits never recorded (FILTER_ZERO=1).
- With TRACE_TIMESTAMP_EN, commits on cycles 3 and 7 after arm -> rd_time reads 3 then 7.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit trace monitor: records register commits (PC, rd, data) into a circular
// FWFT buffer with arm/trigger control and a cycle budget. Optional: TRACE_TIMESTAMP_EN.
module commit_trace_buffer #(
   parameter int DATA_W      = 32,
   parameter int PC_W        = 32,
   parameter int DEPTH       = 16,
   parameter int CYC_W       = 16,
   parameter int MAX_CYCLES  = 30,
   parameter int FILTER_ZERO = 1
) (
   input  logic                     SwitchClk_10,
   input  logic                     reset,
   input  logic                     arm,
   input  logic                     trig_mode,
   input  logic [PC_W-1:0]          trig_pc,
   input  logic                     commit_valid,
   input  logic [PC_W-1:0]          commit_pc,
   input  logic [4:0]               commit_rd,
   input  logic [DATA_W-1:0]        commit_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [PC_W-1:0]          rd_pc,
   output logic [4:0]               rd_reg,
   output logic [DATA_W-1:0]        rd_data,
`ifdef TRACE_TIMESTAMP_EN
   output logic [CYC_W-1:0]         rd_time,
`endif
   output logic [$clog2(DEPTH):0]   count,
   output logic [1:0]               state,
   output logic [CYC_W-1:0]         cycle_count,
   output logic                     halt,
   output logic                     overflow
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
`ifdef TRACE_TIMESTAMP_EN
      logic [CYC_W-1:0]  ts;
`endif
   } entry_t;

   state_t           r_state;
   state_t           w_state_next;
   entry_t           r_mem [DEPTH];
   entry_t           w_wr_entry;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [CYC_W-1:0] r_cycle;
   logic             r_halt;
   logic             r_overflow;

   logic             w_cnt_run;
   logic [CYC_W-1:0] w_cyc_inc;
   logic             w_halt_hit;
   logic             w_trig_hit;
   logic             w_keep;
   logic             w_push_req;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   assign w_cnt_run  = (r_state != S_IDLE) && !r_halt;
   assign w_cyc_inc  = (r_cycle == '1) ? r_cycle : r_cycle + CYC_W'(1);
   assign w_halt_hit = (MAX_CYCLES != 0) && w_cnt_run && (w_cyc_inc == CYC_W'(MAX_CYCLES));
   assign w_trig_hit = (r_state == S_ARMED) && commit_valid && (commit_pc == trig_pc);
   assign w_keep     = commit_valid && !((FILTER_ZERO != 0) && (commit_rd == 5'd0));
   // The triggering commit is recorded even though the FSM is still ARMED this cycle.
   assign w_push_req = !arm && w_keep && ((r_state == S_CAPTURE) || w_trig_hit);
   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_pop      = !arm && rd_valid && rd_ready;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;

   always_comb begin
      // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
      w_state_next = r_state;
      if (arm) begin
         w_state_next = trig_mode ? S_ARMED : S_CAPTURE;
      end else if (w_halt_hit) begin
         w_state_next = S_DONE;
      end else if (w_trig_hit) begin
         w_state_next = S_CAPTURE;
      end
   end

   always_ff @(posedge SwitchClk_10 or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge SwitchClk_10 or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_cycle    <= '0;
         r_halt     <= 1'b0;
         r_overflow <= 1'b0;
      end else if (arm) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_cycle    <= '0;
         r_halt     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_cnt_run)  r_cycle    <= w_cyc_inc;
         if (w_halt_hit) r_halt     <= 1'b1;
         if (w_drop)     r_overflow <= 1'b1;
         if (w_push)     r_wr_ptr   <= r_wr_ptr + AW'(1);
         if (w_pop)      r_rd_ptr   <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_wr_entry      = '0;
      w_wr_entry.pc   = commit_pc;
      w_wr_entry.rd   = commit_rd;
      w_wr_entry.data = commit_data;
`ifdef TRACE_TIMESTAMP_EN
      w_wr_entry.ts   = r_cycle;
`endif
   end

   // NOTE: storage has no reset; outputs are gated by rd_valid so stale contents never show.
   always_ff @(posedge SwitchClk_10) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_wr_entry;
      end
   end

   assign rd_valid    = (r_count != '0);
   assign rd_pc       = rd_valid ? r_mem[r_rd_ptr].pc   : '0;
   assign rd_reg      = rd_valid ? r_mem[r_rd_ptr].rd   : '0;
   assign rd_data     = rd_valid ? r_mem[r_rd_ptr].data : '0;
`ifdef TRACE_TIMESTAMP_EN
   assign rd_time     = rd_valid ? r_mem[r_rd_ptr].ts   : '0;
`endif
   assign count       = r_count;
   assign state       = r_state;
   assign cycle_count = r_cycle;
   assign halt        = r_halt;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_commit_trace_buffer;

   localparam int DEPTH   = 16;
   localparam int MAX_CYC = 30;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        arm = 1'b0;
   logic        trig_mode = 1'b0;
   logic [31:0] trig_pc = '0;
   logic        commit_valid = 1'b0;
   logic [31:0] commit_pc = '0;
   logic [4:0]  commit_rd = '0;
   logic [31:0] commit_data = '0;
   logic        rd_ready = 1'b0;
   logic        rd_valid;
   logic [31:0] rd_pc;
   logic [4:0]  rd_reg;
   logic [31:0] rd_data;
`ifdef TRACE_TIMESTAMP_EN
   logic [15:0] rd_time;
`endif
   logic [4:0]  count;
   logic [1:0]  state;
   logic [15:0] cycle_count;
   logic        halt;
   logic        overflow;

   commit_trace_buffer dut (
      .SwitchClk_10 (clk),
      .reset        (reset),
      .arm          (arm),
      .trig_mode    (trig_mode),
      .trig_pc      (trig_pc),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .commit_rd    (commit_rd),
      .commit_data  (commit_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_pc        (rd_pc),
      .rd_reg       (rd_reg),
      .rd_data      (rd_data),
`ifdef TRACE_TIMESTAMP_EN
      .rd_time      (rd_time),
`endif
      .count        (count),
      .state        (state),
      .cycle_count  (cycle_count),
      .halt         (halt),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [15:0] ts;
   } ent_t;

   ent_t q[$];
   int   m_state;
   int   m_cyc;
   bit   m_halt;
   bit   m_ovf;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_state = 0;
      m_cyc   = 0;
      m_halt  = 0;
      m_ovf   = 0;
   endtask

   // Behavioural rules: arm flushes; pop before push so a full buffer accepts on pop;
   // the budget counts edges outside IDLE until halt.
   task automatic model_step();
      bit pop, run, keep, trig, rec;
      int nc;
      if (!reset) begin
         model_reset();
         return;
      end
      if (arm) begin
         q.delete();
         m_cyc   = 0;
         m_halt  = 0;
         m_ovf   = 0;
         m_state = trig_mode ? 1 : 2;
         return;
      end
      pop  = (q.size() != 0) && rd_ready;
      run  = (m_state != 0) && !m_halt;
      keep = commit_valid && (commit_rd != 5'd0);
      trig = (m_state == 1) && commit_valid && (commit_pc == trig_pc);
      rec  = keep && ((m_state == 2) || trig);
      nc   = run ? ((m_cyc == 65535) ? m_cyc : m_cyc + 1) : m_cyc;
      if (pop) void'(q.pop_front());
      if (rec) begin
         if (q.size() < DEPTH) q.push_back('{commit_pc, commit_rd, commit_data, 16'(m_cyc)});
         else m_ovf = 1;
      end
      if (run && nc == MAX_CYC) begin
         m_halt  = 1;
         m_state = 3;
      end else if (trig) begin
         m_state = 2;
      end
      m_cyc = nc;
   endtask

   task automatic compare_all();
      check("count", 64'(count), 64'(q.size()));
      check("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         check("rd_pc", 64'(rd_pc), 64'(q[0].pc));
         check("rd_reg", 64'(rd_reg), 64'(q[0].rd));
         check("rd_data", 64'(rd_data), 64'(q[0].data));
`ifdef TRACE_TIMESTAMP_EN
         check("rd_time", 64'(rd_time), 64'(q[0].ts));
`endif
      end
      check("state", 64'(state), 64'(m_state));
      check("cycle_count", 64'(cycle_count), 64'(m_cyc));
      check("halt", 64'(halt), 64'(m_halt));
      check("overflow", 64'(overflow), 64'(m_ovf));
   endtask

   task automatic check_reset_values();
      check("rst_count", 64'(count), 64'd0);
      check("rst_state", 64'(state), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_pc", 64'(rd_pc), 64'd0);
      check("rst_rd_reg", 64'(rd_reg), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_cycle", 64'(cycle_count), 64'd0);
      check("rst_halt", 64'(halt), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic drive(input bit a, input bit m, input logic [31:0] tpc, input bit cv,
                        input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d,
                        input bit rdy);
      arm          = a;
      trig_mode    = m;
      trig_pc      = tpc;
      commit_valid = cv;
      commit_pc    = pc;
      commit_rd    = rd;
      commit_data  = d;
      rd_ready     = rdy;
   endtask

   task automatic idle(input bit rdy);
      drive(0, trig_mode, trig_pc, 0, 32'h0, 5'd0, 32'h0, rdy);
   endtask

   logic [31:0] pcs [4];

   initial begin
      pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008; pcs[3] = 32'h300C;
      model_reset();

      // Power-on reset
      #1;
      check_reset_values();
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Immediate capture, two commits, then drain in order
      drive(1, 0, 32'h0, 0, 32'h0, 5'd0, 32'h0, 0);
      tick();
      drive(0, 0, 32'h0, 1, 32'h3000, 5'd8, 32'h5, 0);
      tick();
      drive(0, 0, 32'h0, 1, 32'h3004, 5'd9, 32'hA, 0);
      tick();
      idle(0);
      tick();
      check("basic_first_pc", 64'(rd_pc), 64'h3000);
      check("basic_first_reg", 64'(rd_reg), 64'd8);
      check("basic_first_data", 64'(rd_data), 64'h5);
      idle(1);
      tick();
      check("basic_second_pc", 64'(rd_pc), 64'h3004);
      check("basic_second_data", 64'(rd_data), 64'hA);
      tick();
      check("basic_drained", 64'(rd_valid), 64'd0);

      // PC trigger: only the matching commit and later ones are recorded
      drive(1, 1, 32'h300C, 0, 32'h0, 5'd0, 32'h0, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 32'h300C, 1, 32'h3000 + 32'(4 * i), 5'(i + 1), 32'(100 + i), 0);
         tick();
         if (i < 3) check("trig_armed", 64'(state), 64'd1);
      end
      check("trig_capture", 64'(state), 64'd2);
      check("trig_count", 64'(count), 64'd2);
      check("trig_head_pc", 64'(rd_pc), 64'h300C);

      // Overflow: 18 commits into 16 slots, then push+pop while full
      drive(1, 0, 32'h0, 0, 32'h0, 5'd0, 32'h0, 0);
      tick();
      for (int i = 0; i < 18; i++) begin
         drive(0, 0, 32'h0, 1, 32'h4000 + 32'(4 * i), 5'd7, 32'(i), 0);
         tick();
      end
      check("ovf_count", 64'(count), 64'd16);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_oldest_pc", 64'(rd_pc), 64'h4000);
      drive(0, 0, 32'h0, 1, 32'h5000, 5'd3, 32'h55, 1);
      tick();
      check("full_pushpop_count", 64'(count), 64'd16);
      check("full_pushpop_head", 64'(rd_pc), 64'h4004);

      // Cycle budget with register-0 filtering
      drive(1, 0, 32'h0, 0, 32'h0, 5'd0, 32'h0, 0);
      tick();
      for (int i = 0; i < 35; i++) begin
         drive(0, 0, 32'h0, 1, 32'h6000 + 32'(4 * i), (i % 3 == 0) ? 5'd0 : 5'(i % 31 + 1),
               32'(i), (i < 30));
         tick();
         if (i == 28) check("budget_not_yet", 64'(halt), 64'd0);
         if (i == 29) begin
            check("budget_halt", 64'(halt), 64'd1);
            check("budget_done", 64'(state), 64'd3);
         end
      end
      check("budget_no_push", 64'(count), 64'd1);
      check("budget_cycle_hold", 64'(cycle_count), 64'd30);

      // Reset mid-capture with five entries held
      drive(1, 0, 32'h0, 0, 32'h0, 5'd0, 32'h0, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 32'h0, 1, 32'h7000 + 32'(4 * i), 5'd2, 32'(i), 0);
         tick();
      end
      check("pre_reset_count", 64'(count), 64'd5);
      reset = 1'b0;
      model_reset();
      #1;
      check_reset_values();
      tick();
      check_reset_values();
      reset = 1'b1;
      idle(0);
      tick();

`ifdef TRACE_TIMESTAMP_EN
      // Timestamps capture cycle_count at push
      drive(1, 0, 32'h0, 0, 32'h0, 5'd0, 32'h0, 0);
      tick();
      idle(0);
      for (int i = 0; i < 3; i++) tick();
      drive(0, 0, 32'h0, 1, 32'h8000, 5'd4, 32'h1, 0);
      tick();
      idle(0);
      for (int i = 0; i < 3; i++) tick();
      drive(0, 0, 32'h0, 1, 32'h8004, 5'd5, 32'h2, 0);
      tick();
      idle(0);
      check("ts_first", 64'(rd_time), 64'd3);
      idle(1);
      tick();
      check("ts_second", 64'(rd_time), 64'd7);
      tick();
`endif

      // Random traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 24) == 0), $urandom_range(0, 1), pcs[$urandom_range(0, 3)],
               ($urandom_range(0, 9) < 7), pcs[$urandom_range(0, 3)], 5'($urandom_range(0, 3)),
               $urandom, $urandom_range(0, 1));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
